seq_slice_comparator_ctrl: RTL and testbench
============================================

Name: seq_slice_comparator_ctrl

Overview:
- Sequential magnitude-compare controller. Latches two WIDTH-bit operands and time-multiplexes one SLICE-bit magnitude-compare slice over them, MSB slice first.
- Terminates early on the first unequal slice.
- Sits between operand producers and downstream decision logic, replacing parallel cascaded slices with one shared slice plus sequencing.
- Uses a start/busy/done handshake and reports how many slices were examined.

Parameters:
WIDTH, 8, operand width in bits; legal range WIDTH >= 2.
SLICE, 3, bits compared per cycle; legal range 1 <= SLICE <= WIDTH.
NS (localparam), (WIDTH+SLICE-1)/SLICE, number of slices.
CW (localparam), $clog2(NS+1), width of slices_used.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a compare; sampled only in IDLE.
A  input  WIDTH  operand A; captured on the accepted start edge.
B  input  WIDTH  operand B; captured on the accepted start edge.
busy  output  1  high while in CMP.
done  output  1  one-cycle pulse when the result becomes valid.
A_greater_B  output  1  registered result flag.
A_equal_B  output  1  registered result flag.
A_less_B  output  1  registered result flag.
slices_used  output  CW  number of slices examined for the last result, 1..NS.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - busy=0, done=0.
  - A_greater_B=0, A_equal_B=0, A_less_B=0.
  - slices_used=0.
  - Operand registers=0; slice index=0.
- Slicing:
  - Slice k covers bits [k*SLICE +: SLICE], k=0..NS-1.
  - Bits above WIDTH-1 in the top slice are zero-padded identically for A and B.
  - For 8/3: slice2=[7:6], slice1=[5:3], slice0=[2:0]. Slices never overlap.
- States: IDLE, CMP.
- IDLE:
  - start=1 latches A and B, sets idx=NS-1, and clears all three flags and slices_used.
  - Next state CMP; busy=1 from the next cycle.
- CMP (each edge):
  - Compare slice idx of the latched operands as unsigned.
  - Unequal slice: set A_greater_B or A_less_B, slices_used=NS-idx, done=1, next state IDLE.
  - Equal slice with idx==0: set A_equal_B=1, slices_used=NS, done=1, next state IDLE.
  - Equal slice with idx>0: idx<=idx-1, stay in CMP.
- Latency:
  - start sampled high in cycle c0.
  - busy is high in cycles c1..ck; done is high in cycle c(k+1), where k = slices examined.
  - Worst case NS+1 cycles; best case 2 cycles.
- Result flags:
  - Exactly one flag is high whenever done=1.
  - Flags and slices_used hold until the next accepted start.
  - All flags are 0 while busy=1.
- done is a single-cycle pulse in IDLE.
- Back-to-back: start high in the same cycle as done is accepted. The flags then clear on the next edge.
- start while busy is ignored. Inputs A and B changing during CMP have no effect.
- Reset asserted mid-compare: immediate return to reset values on that edge. No done pulse for the aborted operation.
- Reset has priority over start.

Test Plan:
- Reset for 2 cycles, then idle 3 cycles -> busy=0, done=0, all flags 0, slices_used=0.
- A=8'hA0, B=8'h20, start at c0 -> done at c2, A_greater_B=1, slices_used=1.
- A=8'h45, B=8'h4C, start at c0 -> done at c3, A_less_B=1, slices_used=2.
- A=8'h5A, B=8'h5A -> done at c4, A_equal_B=1, slices_used=3.
- A=8'h81, B=8'h80 -> done at c4, A_greater_B=1, slices_used=3.
- start and operand change at c2 while busy -> ignored; original result at c4.
- rst at c2 mid-compare -> no done; outputs at reset values from c3.
- New start during the done cycle -> accepted; flags 0 next cycle.
- WIDTH=16, SLICE=4: A=16'h1234, B=16'h1235 -> done at c5, A_less_B=1, slices_used=4.

Source files
------------

// File: rtl/seq_slice_comparator_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_slice_comparator_ctrl
//  Purpose  : Sequential magnitude comparator. Latches two WIDTH-bit operands
//             and walks one shared SLICE-bit unsigned compare slice across
//             them, most significant slice first, stopping at the first
//             unequal slice.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start, A, B       - compare request and operands (IDLE only)
//             busy, done        - compare in progress / one-cycle result pulse
//             A_greater_B,
//             A_equal_B,
//             A_less_B          - registered one-hot result flags
//             slices_used       - slices examined for the last result (1..NS)
//  Revision : 1.0  initial release
// ============================================================================
module seq_slice_comparator_ctrl #(
    parameter int WIDTH = 8,
    parameter int SLICE = 3,
    localparam int NS   = (WIDTH + SLICE - 1) / SLICE,
    localparam int CW   = $clog2(NS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_greater_B,
    output logic             A_equal_B,
    output logic             A_less_B,
    output logic [CW-1:0]    slices_used
);

    // Index width is kept at least one bit so a single-slice build is legal.
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    // Operands are widened to a whole number of slices; the top slice is
    // zero-padded identically for A and B so padding never decides a result.
    localparam int PW = NS * SLICE;

    localparam logic [IW-1:0] c_IDX_TOP = IW'(NS - 1);
    localparam logic [CW-1:0] c_NS      = CW'(NS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
    logic [CW-1:0]    r_slices;

    logic [PW-1:0]    w_a_pad;
    logic [PW-1:0]    w_b_pad;
    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [CW-1:0]    w_slices;

    assign w_a_pad  = PW'(r_a);
    assign w_b_pad  = PW'(r_b);
    assign w_sa     = w_a_pad[int'(r_idx) * SLICE +: SLICE];
    assign w_sb     = w_b_pad[int'(r_idx) * SLICE +: SLICE];
    // Slices examined so far, including the one being compared this cycle.
    assign w_slices = c_NS - CW'(r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_gt     <= 1'b0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
            r_slices <= '0;
        end else begin
            // done is a single-cycle pulse; only the terminating edge raises it.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_idx    <= c_IDX_TOP;
                        r_gt     <= 1'b0;
                        r_eq     <= 1'b0;
                        r_lt     <= 1'b0;
                        r_slices <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    // start, A and B are deliberately not looked at here.
                    if (w_sa > w_sb) begin
                        r_gt     <= 1'b1;
                        r_slices <= w_slices;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (w_sa < w_sb) begin
                        r_lt     <= 1'b1;
                        r_slices <= w_slices;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (r_idx == '0) begin
                        r_eq     <= 1'b1;
                        r_slices <= c_NS;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign A_greater_B = r_gt;
    assign A_equal_B   = r_eq;
    assign A_less_B    = r_lt;
    assign slices_used = r_slices;

endmodule
`default_nettype wire

// File: tb/tb_seq_slice_comparator_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seq_slice_comparator_ctrl
//  Purpose  : Scoreboard bench for seq_slice_comparator_ctrl. Two instances:
//             8-bit/3-bit slices and 16-bit/4-bit slices. Issued compares push
//             hand-computed results (flags, slices_used, done cycle) into a
//             queue; a monitor pops and compares on every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_slice_comparator_ctrl;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   su;
        int   dc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // 8/3 instance
    logic        st1 = 1'b0;
    logic [7:0]  a1 = '0;
    logic [7:0]  b1 = '0;
    logic        busy1, done1, gt1, eq1, lt1;
    logic [1:0]  su1;
    // 16/4 instance
    logic        st2 = 1'b0;
    logic [15:0] a2 = '0;
    logic [15:0] b2 = '0;
    logic        busy2, done2, gt2, eq2, lt2;
    logic [2:0]  su2;

    exp_t q1[$];
    exp_t q2[$];

    seq_slice_comparator_ctrl #(.WIDTH(8), .SLICE(3)) u_dut8 (
        .clk(clk), .rst(rst), .start(st1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .A_greater_B(gt1), .A_equal_B(eq1),
        .A_less_B(lt1), .slices_used(su1)
    );

    seq_slice_comparator_ctrl #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(st2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .A_greater_B(gt2), .A_equal_B(eq2),
        .A_less_B(lt2), .slices_used(su2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (busy1 && (gt1 || eq1 || lt1))
                chk("dut8 flags while busy", {gt1, eq1, lt1}, 0);
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("dut8 unexpected done", 1, 0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("dut8 done cycle", cyc, e.dc);
                    chk("dut8 gt", gt1, e.gt);
                    chk("dut8 eq", eq1, e.eq);
                    chk("dut8 lt", lt1, e.lt);
                    chk("dut8 slices_used", su1, e.su);
                    chk("dut8 busy at done", busy1, 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (busy2 && (gt2 || eq2 || lt2))
                chk("dut16 flags while busy", {gt2, eq2, lt2}, 0);
            if (done2) begin
                if (q2.size() == 0) begin
                    chk("dut16 unexpected done", 1, 0);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    chk("dut16 done cycle", cyc, e.dc);
                    chk("dut16 gt", gt2, e.gt);
                    chk("dut16 eq", eq2, e.eq);
                    chk("dut16 lt", lt2, e.lt);
                    chk("dut16 slices_used", su2, e.su);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // All tasks are entered and left #1 after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start for one cycle (cycle c0); k = slices expected to be examined.
    task automatic issue1(input logic [7:0] a, input logic [7:0] b,
                          input logic gt, input logic eq, input logic lt,
                          input int su, input int k, input bit expect_done);
        exp_t e;
        st1 = 1'b1; a1 = a; b1 = b;
        e.gt = gt; e.eq = eq; e.lt = lt; e.su = su; e.dc = cyc + k + 1;
        if (expect_done) q1.push_back(e);
        @(posedge clk); #1;
        st1 = 1'b0;
    endtask

    task automatic issue2(input logic [15:0] a, input logic [15:0] b,
                          input logic gt, input logic eq, input logic lt,
                          input int su, input int k);
        exp_t e;
        st2 = 1'b1; a2 = a; b2 = b;
        e.gt = gt; e.eq = eq; e.lt = lt; e.su = su; e.dc = cyc + k + 1;
        q2.push_back(e);
        @(posedge clk); #1;
        st2 = 1'b0;
    endtask

    task automatic chk_reset_state8(input string tag);
        chk({tag, " busy"}, busy1, 0);
        chk({tag, " done"}, done1, 0);
        chk({tag, " flags"}, {gt1, eq1, lt1}, 0);
        chk({tag, " slices_used"}, su1, 0);
    endtask

    initial begin
        int guard;
        // reset 2 cycles, idle 3
        idle(2);
        rst = 1'b0;
        idle(3);
        chk_reset_state8("reset8");
        chk("reset16 busy", busy2, 0);
        chk("reset16 flags", {gt2, eq2, lt2, done2}, 0);
        chk("reset16 slices_used", su2, 0);

        // top slice decides
        issue1(8'hA0, 8'h20, 1, 0, 0, 1, 1, 1);
        chk("busy in c1", busy1, 1);
        idle(3);
        // middle slice decides
        issue1(8'h45, 8'h4C, 0, 0, 1, 2, 2, 1);
        idle(3);
        // all equal
        issue1(8'h5A, 8'h5A, 0, 1, 0, 3, 3, 1);
        idle(4);
        // LSB slice decides, then result must hold
        issue1(8'h81, 8'h80, 1, 0, 0, 3, 3, 1);
        idle(6);
        chk("hold gt", gt1, 1);
        chk("hold slices_used", su1, 3);
        chk("hold done low", done1, 0);
        // padded top slice [7:6]: 11 vs 10
        issue1(8'hC0, 8'h80, 1, 0, 0, 1, 1, 1);
        idle(3);

        // start and operand change while busy are ignored
        issue1(8'h5A, 8'h5A, 0, 1, 0, 3, 3, 1);      // now in c1
        idle(1);                                      // c2
        st1 = 1'b1; a1 = 8'h00; b1 = 8'hFF;
        idle(1);                                      // c3
        st1 = 1'b0;
        idle(4);

        // reset mid-compare: no done, reset values from c3
        issue1(8'h5A, 8'h5A, 0, 1, 0, 3, 3, 0);      // c1
        idle(1);                                      // c2
        rst = 1'b1;
        idle(1);                                      // c3
        rst = 1'b0;
        chk_reset_state8("abort8");
        idle(5);

        // back-to-back: new start in the done cycle
        issue1(8'hA0, 8'h20, 1, 0, 0, 1, 1, 1);      // c1
        idle(1);                                      // c2 = done cycle
        chk("b2b done in c2", done1, 1);
        issue1(8'h45, 8'h4C, 0, 0, 1, 2, 2, 1);
        chk("b2b busy next", busy1, 1);
        chk("b2b flags cleared", {gt1, eq1, lt1}, 0);
        chk("b2b slices cleared", su1, 0);
        idle(4);

        // 16/4 instance
        issue2(16'h1234, 16'h1235, 0, 0, 1, 4, 4);
        idle(6);
        issue2(16'hF000, 16'h0FFF, 1, 0, 0, 1, 1);
        idle(3);
        issue2(16'hBEEF, 16'hBEEF, 0, 1, 0, 4, 4);
        idle(6);

        guard = 0;
        while ((q1.size() != 0 || q2.size() != 0) && guard < 50) begin
            idle(1);
            guard++;
        end
        chk("dut8 pending results", q1.size(), 0);
        chk("dut16 pending results", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
